ula_arbiter: RTL

Two-port round-robin arbiter and sequencer that shares one 8-bit `ula` instance (registered operands, add/sub, registered result) between two requesters. It owns the ULA operand and opcode inputs, steps each operation through the ULA's register pipeline, and captures the result and flag at the correct cycles. It returns both to the granted requester with a one-cycle `done` pulse.

---
 rtl/ula_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ula_arbiter.sv
`timescale 1ns/1ps
// ula_arbiter
// Round-robin arbiter and sequencer sharing one 8-bit ULA (add/sub, registered
// operands, registered result) between two requesters. A request is accepted
// only in IDLE. The operation is walked through the ULA pipeline
// (ISSUE -> LOAD -> CAPT), and the completion is returned with a one-cycle
// done pulse on the granted port.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req0/req1             requests from port 0 / port 1
//   op0/op1               opcode per port: 000 add, 001 sub, others illegal
//   a0,b0 / a1,b1         operands per port
//   gnt                   one-hot grant, held from ISSUE through DONE
//   done0/done1           one-cycle completion pulse per port
//   res, res_flag, err    result, ULA flag and illegal-opcode indication
//   busy                  high whenever the FSM is not in IDLE
//   ula_a, ula_b, ula_op  registered operands/opcode driven to the ULA
//   ula_s, ula_flag       ULA registered result and combinational flag
module ula_arbiter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic       req1,
    input  logic [2:0] op0,
    input  logic [2:0] op1,
    input  logic [7:0] a0,
    input  logic [7:0] b0,
    input  logic [7:0] a1,
    input  logic [7:0] b1,
    output logic [1:0] gnt,
    output logic       done0,
    output logic       done1,
    output logic [7:0] res,
    output logic       res_flag,
    output logic       err,
    output logic       busy,
    output logic [7:0] ula_a,
    output logic [7:0] ula_b,
    output logic [2:0] ula_op,
    input  logic [7:0] ula_s,
    input  logic       ula_flag
);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_LOAD,
        S_CAPT,
        S_DONE
    } state_t;

    state_t     r_state;
    logic       r_ptr;
    logic       r_flag;
    logic [1:0] r_gnt;
    logic [1:0] r_done;
    logic [7:0] r_res;
    logic       r_res_flag;
    logic       r_err;
    logic       r_busy;
    logic [7:0] r_ula_a;
    logic [7:0] r_ula_b;
    logic [2:0] r_ula_op;

    logic       w_any;
    logic       w_sel;
    logic [1:0] w_sel_onehot;
    logic [2:0] w_op;
    logic [7:0] w_a;
    logic [7:0] w_b;
    logic       w_legal;

    // A lone request wins outright; the pointer only breaks ties.
    assign w_any        = req0 | req1;
    assign w_sel        = (req0 & req1) ? r_ptr : req1;
    assign w_sel_onehot = w_sel ? 2'b10 : 2'b01;
    assign w_op         = w_sel ? op1 : op0;
    assign w_a          = w_sel ? a1  : a0;
    assign w_b          = w_sel ? b1  : b0;
    assign w_legal      = (w_op == OP_ADD) || (w_op == OP_SUB);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= 1'b0;
            r_flag     <= 1'b0;
            r_gnt      <= 2'b00;
            r_done     <= 2'b00;
            r_res      <= 8'h00;
            r_res_flag <= 1'b0;
            r_err      <= 1'b0;
            r_busy     <= 1'b0;
            r_ula_a    <= 8'h00;
            r_ula_b    <= 8'h00;
            r_ula_op   <= 3'b000;
        end else begin
            // done is a pulse: only the transition into DONE raises it.
            r_done <= 2'b00;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt  <= w_sel_onehot;
                        r_busy <= 1'b1;
                        if (w_legal) begin
                            r_ula_a  <= w_a;
                            r_ula_b  <= w_b;
                            r_ula_op <= w_op;
                            r_state  <= S_ISSUE;
                        end else begin
                            // Illegal opcode bypasses the ULA entirely.
                            r_res      <= 8'h00;
                            r_res_flag <= 1'b0;
                            r_err      <= 1'b1;
                            r_done     <= w_sel_onehot;
                            r_state    <= S_DONE;
                        end
                    end
                end
                S_ISSUE: begin
                    r_state <= S_LOAD;
                end
                S_LOAD: begin
                    // The flag is derived from the ULA's operand registers,
                    // which change again once new operands are issued.
                    r_flag  <= ula_flag;
                    r_state <= S_CAPT;
                end
                S_CAPT: begin
                    r_res      <= ula_s;
                    r_res_flag <= r_flag;
                    r_err      <= 1'b0;
                    r_done     <= r_gnt;
                    r_state    <= S_DONE;
                end
                S_DONE: begin
                    r_ptr   <= ~r_gnt[1];
                    r_gnt   <= 2'b00;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt      = r_gnt;
    assign done0    = r_done[0];
    assign done1    = r_done[1];
    assign res      = r_res;
    assign res_flag = r_res_flag;
    assign err      = r_err;
    assign busy     = r_busy;
    assign ula_a    = r_ula_a;
    assign ula_b    = r_ula_b;
    assign ula_op   = r_ula_op;

endmodule
